// File: rtl/rx_checksum.sv
// RX ones-complement checksum: frames pass through combinationally; one folded sum per frame
// reaches the result FIFO two edges after tlast. Input stalls when queued + in-flight results fill the FIFO.
module rx_checksum #(
  parameter int DATA_WIDTH          = 64,
  parameter int KEEP_WIDTH          = DATA_WIDTH / 8,
  parameter int START_OFFSET        = 14,
  parameter int CHECKSUM_FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic [KEEP_WIDTH-1:0] s_axis_tkeep,
  input  logic                  s_axis_tvalid,
  output logic                  s_axis_tready,
  input  logic                  s_axis_tlast,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic [KEEP_WIDTH-1:0] m_axis_tkeep,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic                  m_axis_tlast,
  output logic [15:0]           m_axis_csum,
  output logic                  m_axis_csum_valid,
  input  logic                  m_axis_csum_ready
);

  localparam int NW   = DATA_WIDTH / 16;
  localparam int SW   = 16 + ((NW > 1) ? $clog2(NW) : 0);
  localparam int SAT  = (START_OFFSET + KEEP_WIDTH - 1) / KEEP_WIDTH;
  localparam int BCW  = (SAT < 1) ? 1 : $clog2(SAT + 1);
  localparam int PW   = (CHECKSUM_FIFO_DEPTH > 1) ? $clog2(CHECKSUM_FIFO_DEPTH) : 1;
  localparam int CNTW = $clog2(CHECKSUM_FIFO_DEPTH + 1);

  logic            stall, accept, push, pop;
  logic [BCW-1:0]  beat_cnt_q, beat_cnt_d;
  logic [SW-1:0]   beat_sum, s1_sum_q;
  logic            s1_vld_q, s1_last_q;
  logic [15:0]     acc_q, acc_d, res;
  logic [1:0]      inflight_q, inflight_d;
  logic [15:0]     mem_q [CHECKSUM_FIFO_DEPTH];
  logic [PW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CNTW-1:0] cnt_q;

  function automatic logic [15:0] fold16(input logic [31:0] x);
    logic [31:0] t;
    t = x;
    for (int k = 0; k < 3; k++) t = {16'h0, t[15:0]} + {16'h0, t[31:16]};
    return t[15:0];
  endfunction

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(CHECKSUM_FIFO_DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  // Results already queued plus those still in the pipeline reserve FIFO slots.
  assign stall         = (32'(cnt_q) + 32'(inflight_q)) >= 32'(CHECKSUM_FIFO_DEPTH);
  assign s_axis_tready = m_axis_tready & ~stall & ~rst;
  assign m_axis_tvalid = s_axis_tvalid & ~stall;
  assign m_axis_tdata  = s_axis_tdata;
  assign m_axis_tkeep  = s_axis_tkeep;
  assign m_axis_tlast  = s_axis_tlast;

  assign accept            = s_axis_tvalid & s_axis_tready;
  assign push              = s1_vld_q & s1_last_q;
  assign m_axis_csum_valid = (cnt_q != '0);
  assign pop               = m_axis_csum_valid & m_axis_csum_ready;
  assign m_axis_csum       = m_axis_csum_valid ? mem_q[rd_ptr_q] : 16'h0;

  always_comb begin
    logic [31:0] base;
    logic [7:0]  hi, lo;
    beat_sum = '0;
    hi       = 8'h00;
    lo       = 8'h00;
    base     = 32'(beat_cnt_q) * 32'(KEEP_WIDTH);
    for (int k = 0; k < NW; k++) begin
      hi = (s_axis_tkeep[2*k] && ((base + 32'(2*k)) >= 32'(START_OFFSET)))
           ? s_axis_tdata[16*k +: 8] : 8'h00;
      lo = (s_axis_tkeep[2*k+1] && ((base + 32'(2*k+1)) >= 32'(START_OFFSET)))
           ? s_axis_tdata[16*k+8 +: 8] : 8'h00;
      beat_sum = beat_sum + SW'({hi, lo});
    end
  end

  always_comb begin
    res        = fold16(32'(acc_q) + 32'(s1_sum_q));
    acc_d      = acc_q;
    beat_cnt_d = beat_cnt_q;
    if (s1_vld_q) acc_d = s1_last_q ? 16'h0 : res;
    if (accept) begin
      if (s_axis_tlast)                beat_cnt_d = '0;
      else if (beat_cnt_q < BCW'(SAT)) beat_cnt_d = beat_cnt_q + BCW'(1);
    end
    inflight_d = inflight_q + 2'(accept & s_axis_tlast) - 2'(push);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      beat_cnt_q <= '0;
      s1_sum_q   <= '0;
      s1_vld_q   <= 1'b0;
      s1_last_q  <= 1'b0;
      acc_q      <= 16'h0;
      inflight_q <= 2'd0;
    end else begin
      beat_cnt_q <= beat_cnt_d;
      s1_sum_q   <= beat_sum;
      s1_vld_q   <= accept;
      s1_last_q  <= accept & s_axis_tlast;
      acc_q      <= acc_d;
      inflight_q <= inflight_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < CHECKSUM_FIFO_DEPTH; i++) mem_q[i] <= 16'h0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (push) begin
        mem_q[wr_ptr_q] <= res;
        wr_ptr_q        <= ptr_inc(wr_ptr_q);
      end
      if (pop) rd_ptr_q <= ptr_inc(rd_ptr_q);
      cnt_q <= cnt_q + CNTW'(push) - CNTW'(pop);
    end
  end

endmodule

// File: tb/tb_rx_checksum.sv
// Bench for rx_checksum: byte-level reference sum per frame, per-cycle output compare, directed literals.
module tb_rx_checksum;
  localparam int DW = 64;
  localparam int KW = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic [DW-1:0] s_axis_tdata, m_axis_tdata;
  logic [KW-1:0] s_axis_tkeep, m_axis_tkeep;
  logic          s_axis_tvalid, s_axis_tready, s_axis_tlast;
  logic          m_axis_tvalid, m_axis_tready, m_axis_tlast;
  logic [15:0]   m_axis_csum;
  logic          m_axis_csum_valid, m_axis_csum_ready;

  always #5 clk = ~clk;

  rx_checksum #(.DATA_WIDTH(DW), .KEEP_WIDTH(KW), .START_OFFSET(14), .CHECKSUM_FIFO_DEPTH(4)) dut (
    .clk(clk), .rst(rst),
    .s_axis_tdata(s_axis_tdata), .s_axis_tkeep(s_axis_tkeep), .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tready(s_axis_tready), .s_axis_tlast(s_axis_tlast),
    .m_axis_tdata(m_axis_tdata), .m_axis_tkeep(m_axis_tkeep), .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tready(m_axis_tready), .m_axis_tlast(m_axis_tlast),
    .m_axis_csum(m_axis_csum), .m_axis_csum_valid(m_axis_csum_valid),
    .m_axis_csum_ready(m_axis_csum_ready)
  );

  int          total = 0;
  int          bad = 0;
  int          cyc = 0;
  int          occ = 0;
  int          cur_sum = 0;
  int          cur_idx = 0;
  logic [15:0] exp_q[$];
  int          rdy_q[$];
  logic [15:0] got_q[$];
  logic [7:0]  fb [64];
  logic        m_stall, m_expv;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h (t=%0t)", name, got, want, $time);
    end
  endtask

  function automatic logic [15:0] fold(input int s);
    int t;
    t = s;
    while (t > 65535) t = (t & 65535) + (t >>> 16);
    return 16'(t);
  endfunction

  // Reference: frame occupancy = accepted tlasts minus pops; sum built byte by byte on absolute index.
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      rdy_q.delete();
      occ = 0;
      cur_sum = 0;
      cur_idx = 0;
    end
    m_stall = (occ >= 4);
    chk("pt_data", 64'(m_axis_tdata), 64'(s_axis_tdata));
    chk("pt_keep", 64'(m_axis_tkeep), 64'(s_axis_tkeep));
    chk("pt_last", 64'(m_axis_tlast), 64'(s_axis_tlast));
    chk("m_tvalid", 64'(m_axis_tvalid), 64'(s_axis_tvalid & ~m_stall));
    chk("s_tready", 64'(s_axis_tready), 64'(m_axis_tready & ~m_stall & ~rst));
    m_expv = (exp_q.size() > 0) && (rdy_q[0] <= cyc);
    chk("csum_valid", 64'(m_axis_csum_valid), 64'(m_expv));
    if (m_expv) chk("csum", 64'(m_axis_csum), 64'(exp_q[0]));
    cyc++;
    if (m_axis_csum_valid && m_axis_csum_ready) begin
      got_q.push_back(m_axis_csum);
      if (exp_q.size() > 0) begin
        void'(exp_q.pop_front());
        void'(rdy_q.pop_front());
        occ--;
      end
    end
    if (s_axis_tvalid && s_axis_tready) begin
      for (int i = 0; i < KW; i++)
        if (s_axis_tkeep[i] && (cur_idx + i) >= 14)
          cur_sum += (((cur_idx + i) % 2) == 0) ? (int'(s_axis_tdata[8*i +: 8]) << 8)
                                                : int'(s_axis_tdata[8*i +: 8]);
      cur_idx += KW;
      if (s_axis_tlast) begin
        exp_q.push_back(fold(cur_sum));
        rdy_q.push_back(cyc + 1);
        occ++;
        cur_sum = 0;
        cur_idx = 0;
      end
    end
  end

  task automatic send_beat(input logic [63:0] d, input logic [7:0] k, input logic l);
    bit got;
    int n;
    s_axis_tdata  = d;
    s_axis_tkeep  = k;
    s_axis_tlast  = l;
    s_axis_tvalid = 1'b1;
    got = 1'b0;
    n = 0;
    while (!got && n < 500) begin
      @(negedge clk);
      got = s_axis_tready;
      @(posedge clk);
      #1;
      n++;
    end
    if (!got) chk("accept_timeout", 64'(0), 64'(1));
    s_axis_tvalid = 1'b0;
  endtask

  task automatic send_frame(input int len, input bit extra);
    int nb;
    logic [63:0] d;
    logic [7:0]  k;
    nb = (len + 7) / 8;
    for (int b = 0; b < nb; b++) begin
      d = '0;
      k = '0;
      for (int i = 0; i < KW; i++)
        if (b * 8 + i < len) begin
          d[8*i +: 8] = fb[b*8+i];
          k[i] = 1'b1;
        end
      send_beat(d, k, (b == nb - 1) && !extra);
    end
    if (extra) send_beat(64'hDEAD_BEEF_0BAD_F00D, 8'h00, 1'b1);
  endtask

  task automatic set_frame(input logic [7:0] fill, input logic [7:0] b14, input logic [7:0] b15);
    for (int i = 0; i < 64; i++) fb[i] = fill;
    fb[14] = b14;
    fb[15] = b15;
  endtask

  task automatic wait_results(input int n);
    int t;
    t = 0;
    while (got_q.size() < n && t < 300) begin
      @(posedge clk);
      #1;
      t++;
    end
    if (got_q.size() < n) chk("result_timeout", 64'(got_q.size()), 64'(n));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    rst = 1'b1;
    s_axis_tdata = '0;
    s_axis_tkeep = '0;
    s_axis_tvalid = 1'b0;
    s_axis_tlast = 1'b0;
    m_axis_tready = 1'b1;
    m_axis_csum_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_tready", 64'(s_axis_tready), 64'(0));
    chk("rst_csum_valid", 64'(m_axis_csum_valid), 64'(0));
    chk("rst_csum", 64'(m_axis_csum), 64'(0));
    rst = 1'b0;
    @(posedge clk);
    #1;

    // 1: 16B frame, only bytes 14,15 counted; latency two edges after tlast
    base = got_q.size();
    set_frame(8'hAA, 8'h12, 8'h34);
    send_frame(16, 1'b0);
    chk("t1_lat_edge1", 64'(m_axis_csum_valid), 64'(0));
    @(posedge clk);
    #1;
    chk("t1_lat_edge2", 64'(m_axis_csum_valid), 64'(1));
    wait_results(base + 1);
    chk("t1_csum", 64'(got_q[base]), 64'h1234);

    // 2: pass-through backpressure, then 0xFFFF + 0x0001 end-around carry
    base = got_q.size();
    set_frame(8'h55, 8'hFF, 8'hFF);
    fb[16] = 8'h00; fb[17] = 8'h01;
    for (int i = 18; i < 24; i++) fb[i] = 8'h00;
    m_axis_tready = 1'b0;
    s_axis_tdata = 64'h5555_5555_5555_5555;
    s_axis_tkeep = 8'hFF;
    s_axis_tvalid = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("t2_tready_low", 64'(s_axis_tready), 64'(0));
    m_axis_tready = 1'b1;
    send_frame(24, 1'b0);
    wait_results(base + 1);
    chk("t2_csum", 64'(got_q[base]), 64'h0001);

    // 3: odd trailing byte padded low
    base = got_q.size();
    set_frame(8'h33, 8'hAB, 8'h00);
    send_frame(15, 1'b0);
    wait_results(base + 1);
    chk("t3_csum", 64'(got_q[base]), 64'hAB00);

    // 4: hold result ready low across 6 frames; input must stall at 4 outstanding
    base = got_q.size();
    m_axis_csum_ready = 1'b0;
    fork
      begin
        for (int f = 0; f < 6; f++) begin
          set_frame(8'h00, 8'(16 + f), 8'(f));
          send_frame(16, 1'b0);
        end
      end
      begin
        repeat (40) @(posedge clk);
        #1;
        chk("t4_stall", 64'(s_axis_tready), 64'(0));
        chk("t4_queued", 64'(m_axis_csum_valid), 64'(1));
        m_axis_csum_ready = 1'b1;
      end
    join
    wait_results(base + 6);
    for (int f = 0; f < 6; f++)
      chk("t4_order", 64'(got_q[base+f]), 64'({8'(16 + f), 8'(f)}));

    // 5: short frame, empty tlast beat, 0xFFFF preserved
    base = got_q.size();
    set_frame(8'h77, 8'h77, 8'h77);
    send_frame(10, 1'b0);
    set_frame(8'h11, 8'h5A, 8'hA5);
    send_frame(16, 1'b1);
    set_frame(8'h00, 8'hFF, 8'hFF);
    send_frame(16, 1'b0);
    wait_results(base + 3);
    chk("t5_short", 64'(got_q[base]), 64'h0000);
    chk("t5_empty_last", 64'(got_q[base+1]), 64'h5AA5);
    chk("t5_ffff", 64'(got_q[base+2]), 64'hFFFF);
    repeat (10) @(posedge clk);
    #1;
    chk("t5_count", 64'(got_q.size()), 64'(base + 3));

    // 6: reset mid-frame with two results queued
    m_axis_csum_ready = 1'b0;
    set_frame(8'h00, 8'h01, 8'h02);
    send_frame(16, 1'b0);
    set_frame(8'h00, 8'h03, 8'h04);
    send_frame(16, 1'b0);
    repeat (4) @(posedge clk);
    #1;
    chk("t6_queued", 64'(m_axis_csum_valid), 64'(1));
    send_beat(64'h9999_9999_9999_9999, 8'hFF, 1'b0);
    rst = 1'b1;
    #1;
    chk("t6_rst_valid", 64'(m_axis_csum_valid), 64'(0));
    chk("t6_rst_csum", 64'(m_axis_csum), 64'(0));
    chk("t6_rst_tready", 64'(s_axis_tready), 64'(0));
    @(posedge clk);
    #1;
    rst = 1'b0;
    m_axis_csum_ready = 1'b1;
    base = got_q.size();
    set_frame(8'h21, 8'hC3, 8'h3C);
    send_frame(16, 1'b0);
    wait_results(base + 1);
    chk("t6_after_rst", 64'(got_q[base]), 64'hC33C);
    repeat (10) @(posedge clk);
    #1;
    chk("t6_count", 64'(got_q.size()), 64'(base + 1));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
